// File: rtl/turn_signal_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// turn_signal_input_ctrl_if
// Groups the turn-stalk button inputs and the request/tick outputs that
// connect the input conditioner to its environment.
//   btn_left   raw left button, asynchronous, bouncy, 1 = pressed
//   btn_right  raw right button, asynchronous, bouncy, 1 = pressed
//   left_req   1 while left signalling is requested
//   right_req  1 while right signalling is requested
//   seq_tick   one-clock step enable for the tail-light sequencer
// Modports:
//   master  drives the buttons and observes the conditioned outputs
//   slave   the conditioner itself (turn_signal_input_ctrl)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface turn_signal_input_ctrl_if;
  logic btn_left;
  logic btn_right;
  logic left_req;
  logic right_req;
  logic seq_tick;

  modport master (
    output btn_left,
    output btn_right,
    input  left_req,
    input  right_req,
    input  seq_tick
  );

  modport slave (
    input  btn_left,
    input  btn_right,
    output left_req,
    output right_req,
    output seq_tick
  );
endinterface

// File: rtl/turn_signal_input_ctrl.sv
// ---------------------------------------------------------------------------
// turn_signal_input_ctrl
// Upstream stage of the tail-light sequencer. Each raw turn-stalk button is
// synchronised (2 flops) and debounced; a debounced rising edge becomes a
// one-clock press pulse that toggles a mutually exclusive left/right request.
// While a request is active a divider emits a one-clock seq_tick every
// TICK_DIV clocks.
// Ports:
//   Clk    in  system clock, all logic on posedge
//   Reset  in  asynchronous, active-high reset
//   bus    slave modport of turn_signal_input_ctrl_if
//          (btn_left, btn_right in; left_req, right_req, seq_tick out)
// Parameters:
//   DEB_CYCLES     stable clocks required before a debounced level changes
//   TICK_DIV       clocks per seq_tick period while a request is active
//   TIMEOUT_TICKS  seq_ticks before auto-cancel (AUTO_CANCEL_EN only)
// Optional feature macro: AUTO_CANCEL_EN
//   defined   -> request auto-cancels after TIMEOUT_TICKS seq_ticks
//   undefined -> request persists until cancelled by a button
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module turn_signal_input_ctrl #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int TICK_DIV      = 33554432,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic                     Clk,
  input  logic                     Reset,
  turn_signal_input_ctrl_if.slave  bus
);

  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  if (DEB_CYCLES < 2 || TICK_DIV < 2 || TIMEOUT_TICKS < 2) begin : g_param_check
    $error("turn_signal_input_ctrl: all parameters must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEFT_ON  = 2'd1,
    RIGHT_ON = 2'd2
  } state_t;

  state_t state, next_state;

  // Bit 0 = left, bit 1 = right throughout the conditioning path.
  logic [1:0]       btn_raw;
  logic [1:0]       sync_s1, sync_s2;
  logic [1:0]       deb, deb_d, press;
  logic [DEB_W-1:0] deb_cnt [2];
  logic [DIV_W-1:0] div_cnt;
  logic             seq_tick_r;
  logic             go_left, go_right;
  logic             timeout;
  logic             left_on, right_on;

  assign btn_raw = {bus.btn_right, bus.btn_left};

  // Stage: two-flop synchroniser
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= btn_raw;
      sync_s2 <= sync_s1;
    end
  end

  // Stage: debounce and press-edge detection
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      deb        <= '0;
      deb_d      <= '0;
      press      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_s2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
      deb_d <= deb;
      press <= deb & ~deb_d;
    end
  end

  // A press on both buttons in the same clock is discarded.
  assign go_left  = press[0] & ~press[1];
  assign go_right = press[1] & ~press[0];

  // Stage: request FSM - state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a press always wins over an auto-cancel timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (go_left)       next_state = LEFT_ON;
        else if (go_right) next_state = RIGHT_ON;
      end
      LEFT_ON: begin
        if (go_left)       next_state = IDLE;
        else if (go_right) next_state = RIGHT_ON;
        else if (timeout)  next_state = IDLE;
      end
      RIGHT_ON: begin
        if (go_right)      next_state = IDLE;
        else if (go_left)  next_state = LEFT_ON;
        else if (timeout)  next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode of the state register.
  always_comb begin
    left_on  = 1'b0;
    right_on = 1'b0;
    case (state)
      LEFT_ON:  left_on  = 1'b1;
      RIGHT_ON: right_on = 1'b1;
      default:  ;
    endcase
  end

  // Stage: tick divider. Restarting on every state change makes the first
  // tick land exactly TICK_DIV clocks after entering a request state; a tick
  // that would coincide with the change is dropped.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt    <= '0;
      seq_tick_r <= 1'b0;
    end else if (state == IDLE || next_state != state) begin
      div_cnt    <= '0;
      seq_tick_r <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt    <= '0;
      seq_tick_r <= 1'b1;
    end else begin
      div_cnt    <= div_cnt + DIV_W'(1);
      seq_tick_r <= 1'b0;
    end
  end

`ifdef AUTO_CANCEL_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  logic [TO_W-1:0] tick_cnt;

  // Counts emitted ticks; the TIMEOUT_TICKS-th tick is still seen by the
  // sequencer and the request drops on the following clock.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt <= '0;
    end else if (state == IDLE || next_state != state) begin
      tick_cnt <= '0;
    end else if (seq_tick_r) begin
      tick_cnt <= tick_cnt + TO_W'(1);
    end
  end

  assign timeout = seq_tick_r && (tick_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  assign bus.left_req  = left_on;
  assign bus.right_req = right_on;
  assign bus.seq_tick  = seq_tick_r;

endmodule

// File: tb/tb_turn_signal_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_turn_signal_input_ctrl
// Directed bench for turn_signal_input_ctrl with DEB_CYCLES=4, TICK_DIV=8,
// TIMEOUT_TICKS=3. Inputs change 1 time unit after a rising edge; outputs
// are sampled at the same point, away from the active edge. The press-to-
// request latency is 7 clocks from the first sampling edge, so a button
// driven just after edge e0 gives left_req=1 visible just after edge e8.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_turn_signal_input_ctrl;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  turn_signal_input_ctrl_if bus ();

  turn_signal_input_ctrl #(
    .DEB_CYCLES    (4),
    .TICK_DIV      (8),
    .TIMEOUT_TICKS (3)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic  bl;
    logic  br;
    int    cycles;
    logic  el;
    logic  er;
    logic  et;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic run(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic el, input logic er, input logic et);
    n_checks++;
    if ({bus.left_req, bus.right_req, bus.seq_tick} !== {el, er, et}) begin
      n_fail++;
      $display("FAIL %s: got left_req=%b right_req=%b seq_tick=%b, expected %b %b %b",
               name, bus.left_req, bus.right_req, bus.seq_tick, el, er, et);
    end
  endtask

  function automatic void add(input string name, input logic bl, input logic br,
                              input int cycles, input logic el, input logic er, input logic et);
    vec_t v;
    v.name = name; v.bl = bl; v.br = br; v.cycles = cycles;
    v.el = el; v.er = er; v.et = et;
    vecs.push_back(v);
  endfunction

  initial begin
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    Reset         = 1'b1;
    run(3);
    check("reset_state", 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;

`ifndef AUTO_CANCEL_EN
    // Edge numbers in the notes count from the edge just before the first row.
    add("l_pre",       1, 0, 7, 0, 0, 0);  // e7
    add("l_on",        1, 0, 1, 1, 0, 0);  // e8: LEFT_ON entered
    add("l_notick",    1, 0, 7, 1, 0, 0);  // e15
    add("l_tick1",     1, 0, 1, 1, 0, 1);  // e16: first tick, 8 after entry
    add("l_tick1_end", 1, 0, 1, 1, 0, 0);  // e17
    add("l_hold",      1, 0, 3, 1, 0, 0);  // e20: held 20 clocks total
    add("l_rel",       0, 0, 3, 1, 0, 0);  // e23: release is not a press
    add("l_tick2",     0, 0, 1, 1, 0, 1);  // e24
    add("l_tick2_end", 0, 0, 1, 1, 0, 0);  // e25
    add("bnc_a",       1, 0, 2, 1, 0, 0);  // e27: 2-clock glitches
    add("bnc_b",       0, 0, 2, 1, 0, 0);  // e29
    add("bnc_c",       1, 0, 2, 1, 0, 0);  // e31
    add("bnc_tick",    0, 0, 1, 1, 0, 1);  // e32: tick cadence unchanged
    add("bnc_quiet",   0, 0, 8, 1, 0, 1);  // e40
    add("r_pre",       0, 1, 7, 1, 0, 0);  // e47
    add("r_on",        0, 1, 1, 0, 1, 0);  // e48: switch, due tick dropped
    add("r_notick",    0, 1, 7, 0, 1, 0);  // e55
    add("r_tick",      0, 1, 1, 0, 1, 1);  // e56: divider restarted
    add("r_rel",       0, 0, 8, 0, 1, 1);  // e64
    add("r_off_pre",   0, 1, 7, 0, 1, 0);  // e71
    add("r_off",       0, 1, 1, 0, 0, 0);  // e72: second right press -> IDLE
    add("idle_quiet",  0, 0, 16, 0, 0, 0); // e88: no ticks in IDLE
    add("both_pre",    1, 1, 8, 0, 0, 0);  // e96: simultaneous press ignored
    add("both_hold",   1, 1, 12, 0, 0, 0); // e108
    add("both_rel",    0, 0, 10, 0, 0, 0); // e118

    for (int i = 0; i < vecs.size(); i++) begin
      bus.btn_left  = vecs[i].bl;
      bus.btn_right = vecs[i].br;
      run(vecs[i].cycles);
      check(vecs[i].name, vecs[i].el, vecs[i].er, vecs[i].et);
    end
`endif

    // Reset asserted mid-LEFT_ON clears outputs without waiting for a clock.
    bus.btn_left = 1'b1;
    run(8);
    check("rst_pre", 1'b1, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_async", 1'b0, 1'b0, 1'b0);
    bus.btn_left = 1'b0;
    run(3);
    Reset = 1'b0;
    run(20);
    check("rst_after", 1'b0, 1'b0, 1'b0);

    // Button held through reset release counts as a fresh press.
    Reset = 1'b1;
    bus.btn_left = 1'b1;
    run(2);
    Reset = 1'b0;
    run(7);
    check("hold_rst_pre", 1'b0, 1'b0, 1'b0);
    run(1);
    check("hold_rst_press", 1'b1, 1'b0, 1'b0);

    // Fresh single press, then no further input.
    Reset = 1'b1;
    bus.btn_left = 1'b0;
    run(2);
    Reset = 1'b0;
    bus.btn_left = 1'b1;
    run(8);
    check("ac_on", 1'b1, 1'b0, 1'b0);
    bus.btn_left = 1'b0;
`ifdef AUTO_CANCEL_EN
    run(8);
    check("ac_tick1", 1'b1, 1'b0, 1'b1);
    run(8);
    check("ac_tick2", 1'b1, 1'b0, 1'b1);
    run(8);
    check("ac_tick3", 1'b1, 1'b0, 1'b1);
    run(1);
    check("ac_cancel", 1'b0, 1'b0, 1'b0);
    run(16);
    check("ac_idle", 1'b0, 1'b0, 1'b0);
`else
    for (int c = 1; c <= 104; c++) begin
      run(1);
      // Ticks land every 8 clocks after entry.
      check($sformatf("persist_c%0d", c), 1'b1, 1'b0, (c % 8) == 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
